mem_lsu: RTL

Load/store unit on the MEM-stage side of the data memory; it is the initiator that drives the dm word-array port.
- Accepts one load/store request from the pipeline.
- Converts it into word-granular read/merge/write cycles on dm. Byte lanes are handled in the LSU, so dm only ever sees whole-word accesses.
- Splits accesses that cross a word boundary into two word cycles.
- Returns aligned, sign/zero-extended load data with a completion pulse and a stall signal to the pipeline.

---
 rtl/mem_lsu.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit on the MEM-stage side of the data memory.
//
// The LSU takes one load/store request from the pipeline and turns it into
// whole-word read/merge/write cycles on the dm word port. Byte-lane selection,
// store merging and load alignment/extension all happen here, so dm only ever
// sees word accesses. An access that straddles a word boundary is split into
// two consecutive word cycles (ACC0 at A0, ACC1 at A0+1).
//
// Optional build macro: MEM_LSU_MISALIGN_TRAP_EN
//   defined   - a word-straddling request is not performed; it completes one
//               cycle after accept with rsp_err=1 and rsp_rdata=0.
//   undefined - straddling requests are split; rsp_err flags illegal types only.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   req_valid        request present (held by the pipeline until rsp_valid)
//   req_we           1=store, 0=load
//   req_type         000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned
//   req_addr         byte address
//   req_wdata        store data, right-justified
//   req_pc           PC of the instruction, forwarded on dm_pc
//   stall            req_valid & ~rsp_valid
//   rsp_valid        one-cycle completion pulse
//   rsp_rdata        extended load data (0 for stores and errors)
//   rsp_err          completion was an error
//   dm_we, dm_addr   dm word write enable / word address
//   dm_din           merged write word
//   dm_type          always word (000)
//   dm_pc            latched req_pc
//   dm_dout          dm combinational read data for dm_addr
module mem_lsu #(
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_type,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_pc,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic [2:0]        dm_type,
  output logic [31:0]       dm_pc,
  input  logic [31:0]       dm_dout
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC0 = 2'd1;
  localparam logic [1:0] ST_ACC1 = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

`ifdef MEM_LSU_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  // Access size in bytes; 0 marks an illegal type.
  function automatic logic [2:0] type_size(input logic [2:0] t);
    case (t)
      3'b000:        return 3'd4;
      3'b001, 3'b010: return 3'd2;
      3'b011, 3'b100: return 3'd1;
      default:       return 3'd0;
    endcase
  endfunction

  logic [1:0]        state_reg;
  logic              we_reg;
  logic [2:0]        type_reg;
  logic [1:0]        off_reg;
  logic [ADDR_W-1:0] a0_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       pc_reg;
  logic              split_reg;
  logic              err_reg;
  logic [31:0]       w0_reg;
  logic [23:0]       w1_reg;   // upper byte of the second word never reaches a load result

  // Request decode (only meaningful in IDLE).
  logic [2:0] req_size;
  logic       req_illegal;
  logic       req_split;

  assign req_size    = type_size(req_type);
  assign req_illegal = (req_size == 3'd0);
  assign req_split   = (({1'b0, req_addr[1:0]} + req_size) > 3'd4);

  // Store lane data: the right-justified store data and its byte mask are
  // shifted to the byte offset across a two-word window. The low word feeds
  // ACC0, the high word feeds ACC1.
  logic [3:0]  size_mask;
  logic [7:0]  byte_mask;
  logic [63:0] shifted;

  always_comb begin
    size_mask = 4'h0;
    case (type_size(type_reg))
      3'd4:    size_mask = 4'hF;
      3'd2:    size_mask = 4'h3;
      3'd1:    size_mask = 4'h1;
      default: size_mask = 4'h0;
    endcase
  end

  assign byte_mask = {4'h0, size_mask} << off_reg;
  assign shifted   = {32'h0, wdata_reg} << {off_reg, 3'b000};

  logic       in_acc;
  logic [3:0] lane_mask;
  logic [31:0] lane_word;
  logic [31:0] merged;

  assign in_acc    = (state_reg == ST_ACC0) || (state_reg == ST_ACC1);
  assign lane_mask = (state_reg == ST_ACC1) ? byte_mask[7:4] : byte_mask[3:0];
  assign lane_word = (state_reg == ST_ACC1) ? shifted[63:32] : shifted[31:0];

  // Read-merge-write in the same cycle: untouched lanes come straight from
  // the combinational read of the word being written.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[8*gi +: 8] = lane_mask[gi] ? lane_word[8*gi +: 8] : dm_dout[8*gi +: 8];
    end
  endgenerate

  // dm_we is also gated by rst so a reset landing in ACC1 suppresses that
  // cycle's write at the same edge that returns the FSM to IDLE.
  assign dm_we   = in_acc & we_reg & ~rst;
  assign dm_din  = (in_acc & we_reg) ? merged : 32'h0;
  assign dm_addr = (state_reg == ST_ACC0) ? a0_reg :
                   (state_reg == ST_ACC1) ? (a0_reg + ADDR_W'(1)) : '0;
  assign dm_type = 3'b000;
  assign dm_pc   = pc_reg;

  // Load alignment: pick 32 bits of {w1,w0} starting at the byte offset.
  logic [31:0] load_lo;
  logic [31:0] load_ext;

  always_comb begin
    load_lo = w0_reg;
    case (off_reg)
      2'd0: load_lo = w0_reg;
      2'd1: load_lo = {w1_reg[7:0],  w0_reg[31:8]};
      2'd2: load_lo = {w1_reg[15:0], w0_reg[31:16]};
      2'd3: load_lo = {w1_reg[23:0], w0_reg[31:24]};
      default: load_lo = w0_reg;
    endcase
  end

  always_comb begin
    load_ext = 32'h0;
    case (type_reg)
      3'b000:  load_ext = load_lo;
      3'b001:  load_ext = {{16{load_lo[15]}}, load_lo[15:0]};
      3'b010:  load_ext = {16'h0, load_lo[15:0]};
      3'b011:  load_ext = {{24{load_lo[7]}}, load_lo[7:0]};
      3'b100:  load_ext = {24'h0, load_lo[7:0]};
      default: load_ext = 32'h0;
    endcase
  end

  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_err   = rsp_valid & err_reg;
  assign rsp_rdata = (rsp_valid & ~we_reg & ~err_reg) ? load_ext : 32'h0;
  assign stall     = req_valid & ~rsp_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      we_reg    <= 1'b0;
      type_reg  <= 3'b000;
      off_reg   <= 2'b00;
      a0_reg    <= '0;
      wdata_reg <= 32'h0;
      pc_reg    <= 32'h0;
      split_reg <= 1'b0;
      err_reg   <= 1'b0;
      w0_reg    <= 32'h0;
      w1_reg    <= 24'h0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            we_reg    <= req_we;
            type_reg  <= req_type;
            off_reg   <= req_addr[1:0];
            a0_reg    <= req_addr[ADDR_W+1:2];
            wdata_reg <= req_wdata;
            pc_reg    <= req_pc;
            split_reg <= req_split;
            w0_reg    <= 32'h0;
            w1_reg    <= 24'h0;
            // Illegal types, and straddling accesses when trapping, skip
            // the dm cycles entirely.
            if (req_illegal || (TRAP_EN && req_split)) begin
              err_reg   <= 1'b1;
              state_reg <= ST_RESP;
            end else begin
              err_reg   <= 1'b0;
              state_reg <= ST_ACC0;
            end
          end
        end
        ST_ACC0: begin
          w0_reg    <= dm_dout;
          state_reg <= split_reg ? ST_ACC1 : ST_RESP;
        end
        ST_ACC1: begin
          w1_reg    <= dm_dout[23:0];
          state_reg <= ST_RESP;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
